hdlc_tx_framer: RTL and testbench
=================================

# hdlc_tx_framer

Serial HDLC transmit framer. It takes frame bytes from the TX buffer over a read-strobe handshake and puts them on the line LSB first. It brackets each frame with flags, inserts zeros after five consecutive ones, optionally appends a 16-bit FCS, and generates idle and abort patterns. It sits between the TX buffer and the `Tx` pin, and is the transmit counterpart of the Rx channel.

## Interface
- `FCS_EN`, default 1: append a 16-bit FCS after the last data byte (0 = no FCS).
- `Clk`  in  1: system clock; one line bit per cycle.
- `Rst`  in  1: one clock; reset is asynchronous and active-low.
- `Tx_Enable`  in  1: start request; sampled only in IDLE.
- `Tx_AbortFrame`  in  1: abort request; sampled every cycle.
- `Tx_DataAvail`  in  1: TX buffer holds at least one unread byte.
- `Tx_Data`  in  8: byte at the buffer head; sampled while `Tx_RdBuff`=1.
- `Tx_RdBuff`  out  1: one-cycle pop strobe to the buffer.
- `Tx_NewByte`  out  1: pulses on the first line bit of each data byte.
- `Tx`  out  1: serial line, registered.
- `Tx_ValidFrame`  out  1: high from the first opening-flag bit through the last closing-flag bit.
- `Tx_AbortedTrans`  out  1: sticky abort indication.
- `Tx_Done`  out  1: one-cycle pulse when a frame completes normally.

## Operation
- States:
  - IDLE: `Tx`=1.
  - OPEN: flag 0x7E.
  - DATA.
  - FCS: 16 bits; skipped when `FCS_EN`=0.
  - CLOSE: flag 0x7E.
  - ABORT: 0xFE, which is a 0 followed by seven 1s on the line.
- All patterns go out LSB first.
- IDLE→OPEN on `Tx_Enable`=1 && `Tx_DataAvail`=1. A `Tx_Enable` with `Tx_DataAvail`=0 is ignored. `Tx_Enable` is ignored in every state other than IDLE.
- OPEN→DATA after 8 bits.
- Each time the shifter needs a byte:
  - `Tx_DataAvail`=1: pulse `Tx_RdBuff`, load `Tx_Data`, stay in DATA.
  - `Tx_DataAvail`=0: DATA→FCS (or CLOSE when `FCS_EN`=0).
- FCS→CLOSE after 16 FCS bits plus any stuffed bits. CLOSE→IDLE after 8 bits.
- FCS algorithm:
  - CRC-16-CCITT, reflected polynomial 0x8408, init 0x0000, no final inversion.
  - Computed over unstuffed data bits, LSB first.
  - Cleared on OPEN entry.
  - Transmitted low byte first, LSB first.
- Zero insertion:
  - A 3-bit ones counter runs over DATA and FCS line bits.
  - After the fifth consecutive 1, insert one 0 and hold the shifter for that cycle. The inserted 0 clears the counter.
  - The counter clears on DATA entry. Flags and abort are never stuffed.
  - The counter carries across byte boundaries and across the DATA/FCS boundary.
- Abort:
  - `Tx_AbortFrame`=1 in OPEN, DATA, FCS or CLOSE: →ABORT, set `Tx_AbortedTrans`, drop `Tx_ValidFrame`, issue no further `Tx_RdBuff`.
  - ABORT→IDLE after 8 bits.
  - `Tx_AbortFrame` is ignored in IDLE and ABORT.
  - Unread buffer bytes are left for the buffer owner to flush.
- `Tx_AbortedTrans` clears when the next `Tx_Enable` is accepted.

## Timing
- Reset values (asynchronous): state IDLE, `Tx`=1, and `Tx_ValidFrame`, `Tx_RdBuff`, `Tx_NewByte`, `Tx_Done`, `Tx_AbortedTrans` all 0. The CRC and the ones counter are 0.
- Reset mid-frame truncates the frame immediately, with no abort pattern.
- Start: `Tx_Enable` accepted in cycle N → first flag bit (0) on `Tx` in N+1, and `Tx_ValidFrame`=1 from N+1.
- `Tx_RdBuff` timing:
  - It is asserted in the cycle `Tx` shows the final line bit of the preceding item: the last opening-flag bit, or the last bit of the previous byte including a trailing stuffed 0.
  - `Tx_NewByte` pulses the next cycle, with the byte's bit 0 on `Tx`.
- End of frame:
  - The last closing-flag bit is at cycle M. `Tx_ValidFrame` falls at M+1, and `Tx_Done`=1 at M+1 with `Tx`=1.
  - A new `Tx_Enable` is accepted at M+1 at the earliest, which guarantees at least one idle bit between frames.
- Abort: `Tx_AbortFrame` at cycle N → `Tx`=0 at N+1, `Tx`=1 at N+2..N+8, IDLE at N+9. `Tx_AbortedTrans`=1 from N+1. `Tx_Done` is not pulsed.
- Simultaneous `Tx_AbortFrame` and a `Tx_RdBuff` cycle: abort wins, and `Tx_RdBuff` is suppressed.

## Structure
- `hdlc_pkg` holds:
  - the state enum `tx_state_t`;
  - `HDLC_FLAG`=8'h7E and `HDLC_ABORT`=8'hFE;
  - `HDLC_FCS_POLY`=16'h8408 and `HDLC_FCS_INIT`=16'h0000.
- Sub-module `hdlc_fcs_gen`: bit-serial CRC with `clear`, `bit_en` and `bit_in` inputs and a `fcs[15:0]` output.
- The FSM, shifter, bit counter and stuffing counter live in the top module.

## Test plan
1. Single byte 0x00 with `FCS_EN`=1, `Tx_Enable` at N:
   - `Tx` N+1..N+40 = 01111110, eight 0s, sixteen 0s, 01111110.
   - One `Tx_RdBuff`, at N+8.
   - `Tx_Done` at N+41.
2. Single byte 0xFF with `FCS_EN`=0: data line bits are 11111 0 111 (9 cycles), followed by the closing flag with no stuffing inside the flag.
3. Bytes 0xF0 then 0x01, `FCS_EN`=0:
   - Line shows 0000 1111, then 1, then a stuffed 0, then 0000000.
   - `Tx_NewByte` pulses on the first bit of each byte only.
4. `Tx_AbortFrame` during the third data byte:
   - Line shows 0 followed by seven 1s, then idle.
   - `Tx_AbortedTrans`=1 until the next accepted `Tx_Enable`.
   - No further `Tx_RdBuff` and no `Tx_Done`.
5. `Tx_Enable` with `Tx_DataAvail`=0, and `Tx_Enable` pulsed mid-frame: both are ignored; `Tx` stays 1 and the frame in progress is unaltered.
6. `Rst` low in the middle of the FCS: same cycle, `Tx`=1 and all outputs 0. After release, a new frame starts cleanly with CRC 0.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit framer.
package hdlc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StOpen  = 3'd1,
        StData  = 3'd2,
        StFcs   = 3'd3,
        StClose = 3'd4,
        StAbort = 3'd5
    } tx_state_t;

    localparam logic [7:0]  HDLC_FLAG     = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT    = 8'hFE;
    localparam logic [15:0] HDLC_FCS_POLY = 16'h8408;
    localparam logic [15:0] HDLC_FCS_INIT = 16'h0000;

endpackage

// File: rtl/hdlc_fcs_gen.sv
// Bit-serial reflected CRC-16-CCITT, fed one unstuffed payload bit per enabled cycle.
module hdlc_fcs_gen
    import hdlc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        bit_en_i,
    input  logic        bit_in_i,
    output logic [15:0] fcs_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = HDLC_FCS_INIT;
        end else if (bit_en_i) begin
            crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_in_i) ? HDLC_FCS_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= HDLC_FCS_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign fcs_o = crc_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, LSB-first shifting, zero insertion, optional FCS and abort.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter bit FCS_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_enable_i,
    input  logic       tx_abort_frame_i,
    input  logic       tx_data_avail_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_rd_buff_o,
    output logic       tx_new_byte_o,
    output logic       tx_o,
    output logic       tx_valid_frame_o,
    output logic       tx_aborted_trans_o,
    output logic       tx_done_o
);

    tx_state_t   state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  ones_q, ones_d;
    logic        tx_q, tx_d;
    logic        valid_q, valid_d;
    logic        nb_q, nb_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic        crc_clear, crc_en, crc_bit;
    logic [15:0] fcs;
    logic [3:0]  cnt_inc;
    logic [2:0]  ones_base;
    logic        stuff_now, abort_req, byte_req, pay_bit;

    // bit_cnt_q indexes the bit currently on the line; a stuffed 0 holds it in place.
    assign cnt_inc   = bit_cnt_q + 4'd1;
    assign stuff_now = (ones_q == 3'd5);
    assign abort_req = tx_abort_frame_i && (state_q != StIdle) && (state_q != StAbort);
    assign byte_req  = (bit_cnt_q[2:0] == 3'd7) &&
                       ((state_q == StOpen) || ((state_q == StData) && !stuff_now));
    assign ones_base = (state_q == StData) ? ones_q : 3'd0;

    hdlc_fcs_gen u_fcs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (crc_clear),
        .bit_en_i (crc_en),
        .bit_in_i (crc_bit),
        .fcs_o    (fcs)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ones_d    = ones_q;
        tx_d      = 1'b1;
        valid_d   = valid_q;
        aborted_d = aborted_q;
        nb_d      = 1'b0;
        done_d    = 1'b0;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        crc_bit   = 1'b0;
        pay_bit   = 1'b0;

        if (abort_req) begin
            state_d   = StAbort;
            bit_cnt_d = 4'd0;
            tx_d      = HDLC_ABORT[0];
            valid_d   = 1'b0;
            aborted_d = 1'b1;
            ones_d    = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tx_enable_i && tx_data_avail_i) begin
                        state_d   = StOpen;
                        bit_cnt_d = 4'd0;
                        tx_d      = HDLC_FLAG[0];
                        valid_d   = 1'b1;
                        aborted_d = 1'b0;
                        crc_clear = 1'b1;
                    end
                end
                StOpen, StData: begin
                    if ((state_q == StData) && stuff_now) begin
                        tx_d   = 1'b0;
                        ones_d = 3'd0;
                    end else if (!byte_req) begin
                        bit_cnt_d = cnt_inc;
                        if (state_q == StOpen) begin
                            tx_d = HDLC_FLAG[cnt_inc[2:0]];
                        end else begin
                            pay_bit = shreg_q[cnt_inc[2:0]];
                            tx_d    = pay_bit;
                            ones_d  = pay_bit ? ones_q + 3'd1 : 3'd0;
                            crc_en  = 1'b1;
                            crc_bit = pay_bit;
                        end
                    end else if (tx_data_avail_i) begin
                        state_d   = StData;
                        bit_cnt_d = 4'd0;
                        shreg_d   = tx_data_i;
                        nb_d      = 1'b1;
                        tx_d      = tx_data_i[0];
                        ones_d    = tx_data_i[0] ? ones_base + 3'd1 : 3'd0;
                        crc_en    = 1'b1;
                        crc_bit   = tx_data_i[0];
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (FCS_EN) begin
                            state_d = StFcs;
                            tx_d    = fcs[0];
                            ones_d  = fcs[0] ? ones_base + 3'd1 : 3'd0;
                        end else begin
                            state_d = StClose;
                            tx_d    = HDLC_FLAG[0];
                            ones_d  = 3'd0;
                        end
                    end
                end
                StFcs: begin
                    if (stuff_now) begin
                        tx_d   = 1'b0;
                        ones_d = 3'd0;
                    end else if (bit_cnt_q != 4'd15) begin
                        bit_cnt_d = cnt_inc;
                        pay_bit   = fcs[cnt_inc];
                        tx_d      = pay_bit;
                        ones_d    = pay_bit ? ones_q + 3'd1 : 3'd0;
                    end else begin
                        state_d   = StClose;
                        bit_cnt_d = 4'd0;
                        tx_d      = HDLC_FLAG[0];
                        ones_d    = 3'd0;
                    end
                end
                StClose, StAbort: begin
                    if (bit_cnt_q[2:0] != 3'd7) begin
                        bit_cnt_d = cnt_inc;
                        tx_d      = (state_q == StClose) ? HDLC_FLAG[cnt_inc[2:0]]
                                                         : HDLC_ABORT[cnt_inc[2:0]];
                    end else begin
                        state_d   = StIdle;
                        bit_cnt_d = 4'd0;
                        if (state_q == StClose) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'h00;
            ones_q    <= 3'd0;
            tx_q      <= 1'b1;
            valid_q   <= 1'b0;
            nb_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ones_q    <= ones_d;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            nb_q      <= nb_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign tx_rd_buff_o       = byte_req && tx_data_avail_i && !abort_req;
    assign tx_new_byte_o      = nb_q;
    assign tx_o               = tx_q;
    assign tx_valid_frame_o   = valid_q;
    assign tx_aborted_trans_o = aborted_q;
    assign tx_done_o          = done_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench: two framer instances (with and without FCS) checked against a frame-level line model.
module tb_hdlc_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, ab, avail, sel;
    logic [7:0] data;

    logic tx_a, rd_a, nb_a, val_a, abt_a, done_a;
    logic tx_b, rd_b, nb_b, val_b, abt_b, done_b;
    logic tx, rd, nb, valid, aborted, done;

    logic [7:0] frame_q[$];
    logic [7:0] buf_q[$];
    bit         ab_state[2];
    int         ncheck = 0;
    int         npass  = 0;

    always #5 clk = ~clk;

    hdlc_tx_framer #(.FCS_EN(1'b1)) u_dut_fcs (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .tx_enable_i        (en & ~sel),
        .tx_abort_frame_i   (ab & ~sel),
        .tx_data_avail_i    (avail),
        .tx_data_i          (data),
        .tx_rd_buff_o       (rd_a),
        .tx_new_byte_o      (nb_a),
        .tx_o               (tx_a),
        .tx_valid_frame_o   (val_a),
        .tx_aborted_trans_o (abt_a),
        .tx_done_o          (done_a)
    );

    hdlc_tx_framer #(.FCS_EN(1'b0)) u_dut_nofcs (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .tx_enable_i        (en & sel),
        .tx_abort_frame_i   (ab & sel),
        .tx_data_avail_i    (avail),
        .tx_data_i          (data),
        .tx_rd_buff_o       (rd_b),
        .tx_new_byte_o      (nb_b),
        .tx_o               (tx_b),
        .tx_valid_frame_o   (val_b),
        .tx_aborted_trans_o (abt_b),
        .tx_done_o          (done_b)
    );

    assign tx      = sel ? tx_b   : tx_a;
    assign rd      = sel ? rd_b   : rd_a;
    assign nb      = sel ? nb_b   : nb_a;
    assign valid   = sel ? val_b  : val_a;
    assign aborted = sel ? abt_b  : abt_a;
    assign done    = sel ? done_b : done_a;

    // Builds the expected line for frame_q, then drives the frame and compares every cycle.
    // ab_byte >= 0 aborts ab_off cycles after that byte's first bit; -2 aborts at a random cycle.
    task automatic run_frame(input bit use_fcs, input int ab_byte, input int ab_off,
                             input bit stray, input string name);
        bit          line[$];
        int          rdc[$];
        int          nbc[$];
        int          ones, L, A, T, last_live;
        logic [15:0] crc;
        logic [7:0]  cur, flag;
        bit          b, e_tx, e_rd, e_nb, e_val, e_done, e_ab;
        logic [5:0]  obs, expv;

        sel  = ~use_fcs;
        flag = 8'h7E;
        for (int i = 0; i < 8; i++) line.push_back(flag[i]);
        ones = 0;
        crc  = 16'h0000;
        foreach (frame_q[j]) begin
            cur = frame_q[j];
            rdc.push_back(line.size());
            nbc.push_back(line.size() + 1);
            crc = crc ^ {8'h00, cur};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
            for (int k = 0; k < 8; k++) begin
                b = cur[k];
                line.push_back(b);
                ones = b ? ones + 1 : 0;
                if (ones == 5) begin
                    line.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        if (use_fcs) begin
            for (int k = 0; k < 16; k++) begin
                b = crc[k];
                line.push_back(b);
                ones = b ? ones + 1 : 0;
                if (ones == 5) begin
                    line.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < 8; i++) line.push_back(flag[i]);
        L = line.size();

        if (ab_byte >= 0 && ab_byte < nbc.size()) A = nbc[ab_byte] + ab_off;
        else if (ab_byte == -2) A = $urandom_range(1, L);
        else A = 0;
        last_live = (A > 0) ? A + 8 : L;
        T = ((last_live > L) ? last_live : L) + 4;

        buf_q = frame_q;
        for (int c = 0; c < T; c++) begin
            @(negedge clk);
            en    = (c == 0) || (stray && c >= 1 && c <= last_live && $urandom_range(0, 2) == 0);
            ab    = (A > 0) && (c == A);
            avail = (buf_q.size() != 0);
            data  = avail ? buf_q[0] : 8'($urandom);
            #1;
            e_tx   = (c >= 1 && c <= L) ? line[c-1] : 1'b1;
            e_rd   = 1'b0;
            e_nb   = 1'b0;
            foreach (rdc[i]) if (rdc[i] == c) e_rd = 1'b1;
            foreach (nbc[i]) if (nbc[i] == c) e_nb = 1'b1;
            e_val  = (c >= 1 && c <= L);
            e_done = (c == L + 1);
            e_ab   = (c == 0) ? ab_state[sel] : 1'b0;
            if (A > 0 && c >= A) e_rd = 1'b0;
            if (A > 0 && c > A) begin
                e_tx   = (c != A + 1);
                e_nb   = 1'b0;
                e_val  = 1'b0;
                e_done = 1'b0;
                e_ab   = 1'b1;
            end
            expv = {e_tx, e_rd, e_nb, e_val, e_done, e_ab};
            obs  = {tx, rd, nb, valid, done, aborted};
            ncheck++;
            if (obs !== expv)
                $display("FAIL %s cycle %0d: tx/rd/newbyte/valid/done/aborted got %b expected %b",
                         name, c, obs, expv);
            else
                npass++;
            if (rd === 1'b1) void'(buf_q.pop_front());
        end
        en = 1'b0;
        ab = 1'b0;
        avail = 1'b0;
        buf_q.delete();
        ab_state[sel] = (A > 0);
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        @(negedge clk);
        #1;
        obs = {tx_a, rd_a, nb_a, val_a, done_a, abt_a};
        ncheck++;
        if (obs !== 6'b100000) $display("FAIL reset_fcs: got %b expected 100000", obs);
        else npass++;
        obs = {tx_b, rd_b, nb_b, val_b, done_b, abt_b};
        ncheck++;
        if (obs !== 6'b100000) $display("FAIL reset_nofcs: got %b expected 100000", obs);
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_zero();
        frame_q = '{8'h00};
        run_frame(1'b1, -1, 0, 1'b0, "single_00_fcs");
    endtask

    task automatic test_single_ff_nofcs();
        frame_q = '{8'hFF};
        run_frame(1'b0, -1, 0, 1'b0, "single_ff_nofcs");
    endtask

    task automatic test_stuff_across_bytes();
        frame_q = '{8'hF0, 8'h01};
        run_frame(1'b0, -1, 0, 1'b0, "f0_01_nofcs");
        frame_q = '{8'h7E, 8'hFF, 8'hF8};
        run_frame(1'b1, -1, 0, 1'b0, "stuff_fcs");
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 8; f++) begin
            frame_q.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++)
                frame_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            run_frame(bit'($urandom_range(0, 1)), -1, 0, 1'b0, "random_frame");
        end
    endtask

    task automatic test_abort();
        frame_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        run_frame(1'b1, 2, 3, 1'b0, "abort_third_byte");
        frame_q = '{8'hA5};
        run_frame(1'b1, -1, 0, 1'b0, "after_abort");
        for (int f = 0; f < 4; f++) begin
            frame_q = '{8'($urandom), 8'hFF, 8'($urandom)};
            run_frame(bit'(f % 2), -2, 0, 1'b0, "abort_random");
        end
        frame_q = '{8'h3C};
        run_frame(1'b0, -1, 0, 1'b0, "after_abort_nofcs");
    endtask

    task automatic test_enable_ignored();
        logic [4:0] obs;
        sel = 1'b0;
        buf_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            en    = (c < 3);
            avail = 1'b0;
            data  = 8'($urandom);
            #1;
            obs = {tx, valid, rd, nb, done};
            ncheck++;
            if (obs !== 5'b10000)
                $display("FAIL enable_no_data cycle %0d: tx/valid/rd/nb/done got %b expected 10000",
                         c, obs);
            else
                npass++;
        end
        en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame_q = '{8'($urandom), 8'($urandom), 8'hFF};
            run_frame(bit'(f % 2), -1, 0, 1'b1, "stray_enable");
        end
    endtask

    task automatic test_reset_mid_fcs();
        logic [1:0] mid;
        logic [5:0] obs;
        sel = 1'b0;
        buf_q = '{8'h00};
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            en    = (c == 0);
            avail = (buf_q.size() != 0);
            data  = avail ? buf_q[0] : 8'h00;
            #1;
            if (rd === 1'b1) void'(buf_q.pop_front());
        end
        // Cycle 20 lies inside the 16 FCS bits (17..32) of a single 0x00 byte.
        mid = {tx, valid};
        ncheck++;
        if (mid !== 2'b01) $display("FAIL in_fcs_before_reset: tx/valid got %b expected 01", mid);
        else npass++;
        rst_n = 1'b0;
        #1;
        obs = {tx, rd, nb, valid, done, aborted};
        ncheck++;
        if (obs !== 6'b100000) $display("FAIL reset_mid_fcs: got %b expected 100000", obs);
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        avail = 1'b0;
        buf_q.delete();
        ab_state[0] = 1'b0;
        ab_state[1] = 1'b0;
        frame_q = '{8'hC3, 8'($urandom)};
        run_frame(1'b1, -1, 0, 1'b0, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ab    = 1'b0;
        avail = 1'b0;
        data  = 8'h00;
        sel   = 1'b0;
        ab_state[0] = 1'b0;
        ab_state[1] = 1'b0;
        test_reset();
        test_single_zero();
        test_single_ff_nofcs();
        test_stuff_across_bytes();
        test_random_frames();
        test_abort();
        test_enable_ignored();
        test_reset_mid_fcs();
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
